// File: rtl/pipe_em_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_em_skid_if
// Execute-to-memory pipeline handshake bundle.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// exactly when valid and ready are both 1 in the cycle before that edge.
// A source may not withdraw or change its payload based on ready. Ready
// may be 1 while valid is 0.
//
// Signals:
//   validE   : execute stage offers payloadE
//   readyE   : skid buffer can accept payloadE this cycle
//   payloadE : packed execute-stage bundle (PW bits)
//   validM   : payloadM holds a live instruction
//   readyM   : memory stage consumes payloadM this cycle
//   payloadM : packed memory-stage bundle (PW bits)
//
// Modports:
//   master : the pipeline surroundings (drives validE/payloadE/readyM)
//   slave  : the skid buffer itself (drives readyE/validM/payloadM)
// ---------------------------------------------------------------------------
interface pipe_em_skid_if #(
    parameter int WIDTH = 32
);
    localparam int PW = 4 * WIDTH + 12;

    logic          validE;
    logic          readyE;
    logic [PW-1:0] payloadE;
    logic          validM;
    logic          readyM;
    logic [PW-1:0] payloadM;

    modport master (
        output validE,
        output payloadE,
        output readyM,
        input  readyE,
        input  validM,
        input  payloadM
    );

    modport slave (
        input  validE,
        input  payloadE,
        input  readyM,
        output readyE,
        output validM,
        output payloadM
    );
endinterface

// File: rtl/pipe_em_skid.sv
// ---------------------------------------------------------------------------
// pipe_em_skid
// Two-entry skid buffer sitting between the execute and memory stages.
// Payload layout, MSB to LSB:
//   regwrite[1] resultsrc[2] memwrite[1] immext[WIDTH] aluresult[WIDTH]
//   writedata[WIDTH] rd[5] pcplus4[WIDTH] funct3[3]
// The fields are carried bit-exact; nothing is decoded here.
//
// Ports:
//   clk       : clock, all state changes on posedge
//   rst       : asynchronous active-low reset
//   flush     : synchronous kill of held and incoming entries
//   bus       : E/M handshake bundle (slave side)
//   stall_cnt : saturating count of cycles with validM=1 and readyM=0
//   o_state   : current buffer state (EMPTY=0, FULL=1, SKID=2) for debug
// ---------------------------------------------------------------------------
module pipe_em_skid #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_em_skid_if.slave    bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       o_state
);
    localparam int PW = 4 * WIDTH + 12;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // no entry held
        FULL  = 2'd1,  // main entry only
        SKID  = 2'd2   // main and skid entries
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_main;
    logic [PW-1:0]   r_skid;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_consume;
    logic w_load_main;       // main <= payloadE
    logic w_main_from_skid;  // main <= skid
    logic w_load_skid;       // skid <= payloadE
    logic w_stall;

    // readyE depends on registered state only, so there is no
    // combinational path from readyM back to the execute stage.
    assign bus.readyE   = (r_state != SKID);
    assign bus.validM   = (r_state != EMPTY);
    assign bus.payloadM = r_main;
    assign stall_cnt    = r_cnt;
    assign o_state      = r_state;

    assign w_accept  = bus.validE & bus.readyE;
    assign w_consume = bus.validM & bus.readyM;
    assign w_stall   = bus.validM & ~bus.readyM;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (flush) begin
            // Only the state (i.e. the valid bits) is cleared; payload
            // registers keep whatever they last held.
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = FULL;
                        w_load_main = 1'b1;
                    end
                end
                FULL: begin
                    if (w_accept && w_consume) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = SKID;
                        w_load_skid = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (w_consume) begin
                        w_state_nxt      = FULL;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main <= bus.payloadE;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= bus.payloadE;
            end
        end
    end

    // Stall counter saturates and ignores flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_pipe_em_skid.sv
module tb_pipe_em_skid;
  localparam int W  = 32;
  localparam int PW = 4 * W + 12;
  localparam int ALU_LSB = 2 * W + 8;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;
  localparam int unsigned CNT_MAX16 = 65535;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;
  logic [1:0]  state;
  logic [1:0]  state4;

  always #5 clk = ~clk;

  pipe_em_skid_if #(.WIDTH(W)) bus ();
  pipe_em_skid_if #(.WIDTH(W)) bus4 ();

  assign bus4.validE   = bus.validE;
  assign bus4.payloadE = bus.payloadE;
  assign bus4.readyM   = bus.readyM;

  pipe_em_skid #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
    .stall_cnt(stall_cnt), .o_state(state)
  );

  pipe_em_skid #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus4.slave),
    .stall_cnt(stall_cnt4), .o_state(state4)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- scoreboard / reference model ----------------
  logic [PW-1:0] exp_q[$];
  int unsigned   exp_cnt;

  task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Two-slot FIFO view of the buffer: capacity 2, head is payloadM.
  task automatic model_edge(input logic ve, input logic rm, input logic fl, input logic [PW-1:0] pe);
    bit acc;
    bit con;
    acc = ve && (exp_q.size() < 2);
    con = (exp_q.size() > 0) && rm;
    if ((exp_q.size() > 0) && !rm && (exp_cnt < CNT_MAX16)) exp_cnt++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(pe);
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, ".validM"}, PW'(bus.validM), PW'(exp_q.size() > 0));
    check({tag, ".readyE"}, PW'(bus.readyE), PW'(exp_q.size() < 2));
    check({tag, ".stall_cnt"}, PW'(stall_cnt), PW'(exp_cnt));
    if (exp_q.size() > 0) check({tag, ".payloadM"}, bus.payloadM, exp_q[0]);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [PW-1:0] pack(
    input logic regwrite, input logic [1:0] resultsrc, input logic memwrite,
    input logic [W-1:0] immext, input logic [W-1:0] alu, input logic [W-1:0] wd,
    input logic [4:0] rd, input logic [W-1:0] pc4, input logic [2:0] f3);
    return {regwrite, resultsrc, memwrite, immext, alu, wd, rd, pc4, f3};
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] p;
    for (int i = 0; i < PW; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic drive(input logic ve, input logic rm, input logic fl, input logic [PW-1:0] pe);
    bus.validE   = ve;
    bus.readyM   = rm;
    flush        = fl;
    bus.payloadE = pe;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         ve;
    logic         rm;
    logic         fl;
    logic [W-1:0] alu;
    logic         e_vm;
    logic         e_re;
    logic [W-1:0] e_alu;
    logic [15:0]  e_cnt;
    logic [1:0]   e_st;
  } vec_t;

  vec_t tbl[14];
  logic [PW-1:0] exp_pat;
  logic [PW-1:0] p;

  initial begin
    // inputs for one edge | outputs after that edge
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd1,  1'b1, 1'b1, 32'd1,  16'd0, ST_FULL};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'd2,  1'b1, 1'b1, 32'd2,  16'd0, ST_FULL};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'd3,  1'b1, 1'b1, 32'd3,  16'd0, ST_FULL};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'd4,  1'b1, 1'b1, 32'd4,  16'd0, ST_FULL};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd4,  16'd0, ST_EMPTY};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'd10, 1'b1, 1'b1, 32'd10, 16'd0, ST_FULL};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'd11, 1'b1, 1'b0, 32'd10, 16'd1, ST_SKID};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'd12, 1'b1, 1'b0, 32'd10, 16'd2, ST_SKID};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd11, 16'd2, ST_FULL};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd11, 16'd2, ST_EMPTY};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 1'b1, 32'd20, 16'd2, ST_FULL};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'd21, 1'b1, 1'b0, 32'd20, 16'd3, ST_SKID};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'd22, 1'b0, 1'b1, 32'd20, 16'd3, ST_EMPTY};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd20, 16'd3, ST_EMPTY};

    drive(1'b0, 1'b0, 1'b0, '0);
    exp_q.delete();
    exp_cnt = 0;

    // Reset values while held in reset
    @(negedge clk);
    check("rst.validM", PW'(bus.validM), PW'(0));
    check("rst.readyE", PW'(bus.readyE), PW'(1));
    check("rst.payloadM", bus.payloadM, '0);
    check("rst.stall_cnt", PW'(stall_cnt), PW'(0));
    do_reset();

    // Streaming, backpressure, flush
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ve, tbl[i].rm, tbl[i].fl, pack(0, 0, 0, 0, tbl[i].alu, 0, 0, 0, 0));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d.validM", i), PW'(bus.validM), PW'(tbl[i].e_vm));
      check($sformatf("tbl%0d.readyE", i), PW'(bus.readyE), PW'(tbl[i].e_re));
      check($sformatf("tbl%0d.alu", i), PW'(bus.payloadM[ALU_LSB +: W]), PW'(tbl[i].e_alu));
      check($sformatf("tbl%0d.stall_cnt", i), PW'(stall_cnt), PW'(tbl[i].e_cnt));
      check($sformatf("tbl%0d.state", i), PW'(state), PW'(tbl[i].e_st));
    end
    drive(1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset from SKID, then first acceptance right after release
    do_reset();
    drive(1'b1, 1'b0, 1'b0, pack(0, 0, 0, 0, 32'h55, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("arst.pre_state", PW'(state), PW'(ST_SKID));
    check("arst.pre_readyE", PW'(bus.readyE), PW'(0));
    #2 rst = 1'b0;
    #1;
    check("arst.validM", PW'(bus.validM), PW'(0));
    check("arst.readyE", PW'(bus.readyE), PW'(1));
    check("arst.payloadM", bus.payloadM, '0);
    check("arst.stall_cnt", PW'(stall_cnt), PW'(0));
    check("arst.state", PW'(state), PW'(ST_EMPTY));
    @(negedge clk);
    rst = 1'b1;
    p = rand_payload();
    drive(1'b1, 1'b1, 1'b0, p);
    @(posedge clk);
    @(negedge clk);
    check("arst.first_validM", PW'(bus.validM), PW'(1));
    check("arst.first_payload", bus.payloadM, p);
    drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);

    // Bit-exact packing
    do_reset();
    drive(1'b1, 1'b1, 1'b0, pack(1'b1, 2'b00, 1'b0, '0, '0, '0, 5'h1F, '0, 3'b101));
    exp_pat = '0;
    exp_pat[PW-1] = 1'b1;
    exp_pat[W+7:W+3] = 5'h1F;
    exp_pat[2:0] = 3'b101;
    @(posedge clk);
    @(negedge clk);
    check("pack.payloadM", bus.payloadM, exp_pat);
    drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);

    // Counter saturation (4-bit instance) vs. 16-bit instance
    do_reset();
    drive(1'b1, 1'b0, 1'b0, rand_payload());
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (15) @(negedge clk);
    check("sat.cnt4_at15", PW'(stall_cnt4), PW'(15));
    repeat (5) @(negedge clk);
    check("sat.cnt4_held", PW'(stall_cnt4), PW'(15));
    check("sat.cnt16", PW'(stall_cnt), PW'(20));
    check("sat.validM4", PW'(bus4.validM), PW'(1));

    // Randomized run against the FIFO model
    do_reset();
    model_check("rnd.init");
    for (int n = 0; n < 400; n++) begin
      logic ve;
      logic rm;
      logic fl;
      logic [PW-1:0] pe;
      ve = ($urandom_range(0, 3) != 0);
      rm = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      pe = rand_payload();
      drive(ve, rm, fl, pe);
      @(posedge clk);
      model_edge(ve, rm, fl, pe);
      @(negedge clk);
      model_check($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pipe_em_skid.md
PIPE_EM_SKID -- requirements
Module: pipe_em_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of immext/aluresult/writedata/pcplus4 fields.
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-003 SHALL define PW = 4*WIDTH+12 (payload width).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 validE  in  1  execute stage offers payloadE.
REQ-007 readyE  out  1  block can accept payloadE this cycle.
REQ-008 payloadE  in  PW  packed execute-stage bundle.
REQ-009 flush  in  1  synchronous kill of all held and incoming entries.
REQ-010 validM  out  1  payloadM holds a live instruction.
REQ-011 readyM  in  1  memory stage consumes payloadM this cycle.
REQ-012 payloadM  out  PW  packed memory-stage bundle.
REQ-013 stall_cnt  out  CNT_W  cycles with validM=1 and readyM=0.
REQ-014 SHALL pack the payload MSB to LSB as: regwrite[1], resultsrc[2], memwrite[1], immext[WIDTH], aluresult[WIDTH], writedata[WIDTH], rd[5], pcplus4[WIDTH], funct3[3].

Function
REQ-015 SHALL hold two entries, main and skid, each a valid bit plus PW-bit payload; payloadM SHALL always be the main payload.
REQ-016 Accept = validE & readyE; consume = validM & readyM; readyE SHALL equal NOT skid-valid, from registered state only (no combinational path from readyM).
REQ-017 States: EMPTY (no valid entry), FULL (main only), SKID (main and skid); validM=1 in FULL and SKID.
REQ-018 EMPTY: accept -> FULL, main<=payloadE.
REQ-019 FULL: accept & consume -> FULL, main<=payloadE; accept & !consume -> SKID, skid<=payloadE; !accept & consume -> EMPTY; else hold.
REQ-020 SKID: readyE=0; consume -> FULL, main<=skid; else hold.
REQ-021 Latency SHALL be one cycle: a payload accepted at edge N appears on payloadM with validM=1 after edge N when main was empty or consumed.
REQ-022 Throughput SHALL be one transfer per cycle with readyM held 1; no bubbles.
REQ-023 Entries SHALL leave in acceptance order; no payload SHALL be dropped or duplicated except by flush.
REQ-024 flush=1 SHALL force EMPTY at the next edge from any state, overriding simultaneous accept and consume; the incoming payload is discarded.
REQ-025 flush SHALL clear valid bits only; payload registers retain their last value.
REQ-026 stall_cnt SHALL increment by 1 each cycle validM=1 and readyM=0, saturate at 2^CNT_W-1, never wrap, and be unaffected by flush.
REQ-027 Payload contents SHALL be passed bit-exact; the block performs no decode or arithmetic on fields.

Reset
REQ-028 rst=0 SHALL asynchronously force EMPTY, validM=0, readyE=1, payloadM=0, skid payload=0, stall_cnt=0.
REQ-029 Reset asserted mid-operation SHALL discard both entries immediately; first acceptance is possible at the first posedge after rst deasserts.

Verification
REQ-030 Reset: rst=0 with FULL/SKID state -> validM=0, readyE=1, payloadM=0, stall_cnt=0 without a clock edge.
REQ-031 Streaming: readyM=1, validE=1 with aluresult=1,2,3,4 on consecutive cycles -> payloadM aluresult 1,2,3,4 on the next four cycles, validM continuous.
REQ-032 Backpressure: readyM=0, offer A then B -> state SKID, readyE=0, stall_cnt increments each cycle; raise readyM -> A then B in order, readyE=1 after A leaves.
REQ-033 Flush: in SKID with validE=1, readyM=1, flush=1 -> next cycle validM=0, EMPTY, input not captured, stall_cnt unchanged.
REQ-034 Saturation: CNT_W=4, readyM=0 with validM=1 for 20 cycles -> stall_cnt stops at 15.
REQ-035 Packing: payloadE with rd=5'h1F, funct3=3'b101, regwrite=1, others 0 -> identical payloadM bit pattern.
